// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg -- shared FSM state type and mode encodings for demux_1x2_sched.
`default_nettype none

package demux_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD0 = 2'd1,
      HOLD1 = 2'd2
   } state_t;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_DIR = 1'b1;

   function automatic state_t hold_state(input logic ch);
      return ch ? HOLD1 : HOLD0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1x2_sched_demux.sv
// demux_1x2_sched_demux -- combinational 1x2 demux; the unselected (or disabled) output
// is driven to zero.
`default_nettype none

module demux_1x2_sched_demux #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] din,
   input  logic              sel,
   input  logic              en,
   output logic [DATA_W-1:0] dout0,
   output logic [DATA_W-1:0] dout1
);

   always_comb begin
      dout0 = '0;
      dout1 = '0;
      if (en) begin
         if (sel) dout1 = din;
         else     dout0 = din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/demux_1x2_sched.sv
// demux_1x2_sched -- one-word buffered 1x2 demux, round-robin or directed steering.
// Optional per-channel delivery counters under DEMUX_SCHED_STATS_EN.
`default_nettype none

module demux_1x2_sched
   import demux_sched_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_dest,
   input  logic              mode,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              sel,
   output logic              busy
`ifdef DEMUX_SCHED_STATS_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
`endif
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] held_q, held_d;
   logic              rr_q, rr_d;
   logic              rr_mode_q, rr_mode_d;   // held word was accepted in round-robin mode
   logic              ready_en_q;             // holds in_ready low until the first edge after reset

   logic              xfer0, xfer1, complete, accept, target;

   assign busy       = (state_q != IDLE);
   assign sel        = (state_q == HOLD1);
   assign out0_valid = (state_q == HOLD0);
   assign out1_valid = (state_q == HOLD1);
   assign xfer0      = out0_valid & out0_ready;
   assign xfer1      = out1_valid & out1_ready;
   assign complete   = xfer0 | xfer1;
   assign in_ready   = ready_en_q & (busy ? (sel ? out1_ready : out0_ready) : 1'b1);
   assign accept     = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      rr_d      = rr_q;
      rr_mode_d = rr_mode_q;
      target    = 1'b0;
      if (complete && rr_mode_q) rr_d = ~rr_q;
      // A coincident accept steers with the already-toggled pointer.
      if (accept) begin
         target    = (mode == MODE_DIR) ? in_dest : rr_d;
         state_d   = hold_state(target);
         held_d    = in_data;
         rr_mode_d = (mode == MODE_RR);
      end else if (complete) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         held_q     <= '0;
         rr_q       <= 1'b0;
         rr_mode_q  <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         held_q     <= held_d;
         rr_q       <= rr_d;
         rr_mode_q  <= rr_mode_d;
         ready_en_q <= 1'b1;
      end
   end

   demux_1x2_sched_demux #(
      .DATA_W (DATA_W)
   ) u_demux (
      .din   (held_q),
      .sel   (sel),
      .en    (busy),
      .dout0 (out0_data),
      .dout1 (out1_data)
   );

`ifdef DEMUX_SCHED_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (xfer0) cnt0_d = cnt0_q + CNT_ONE;
      if (xfer1) cnt1_d = cnt1_q + CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_1x2_sched.sv
// tb_demux_1x2_sched -- directed self-checking bench for demux_1x2_sched.
`default_nettype none

module tb_demux_1x2_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_dest = 1'b0;
   logic       mode = 1'b0;
   logic       out0_valid, out1_valid;
   logic       out0_ready = 1'b1;
   logic       out1_ready = 1'b1;
   logic [7:0] out0_data, out1_data;
   logic       sel, busy;
`ifdef DEMUX_SCHED_STATS_EN
   logic [3:0] cnt0, cnt1;
`endif

   always #5 clk = ~clk;

   demux_1x2_sched #(
      .DATA_W (8),
      .CNT_W  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_dest    (in_dest),
      .mode       (mode),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .sel        (sel),
      .busy       (busy)
`ifdef DEMUX_SCHED_STATS_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Independent handshake monitor: counts and records completed output transfers.
   int         h0 = 0, h1 = 0;
   logic [7:0] last0 = 8'h00, last1 = 8'h00;
   always @(posedge clk) begin
      if (out0_valid && out0_ready) begin h0++; last0 = out0_data; end
      if (out1_valid && out1_ready) begin h1++; last1 = out1_data; end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   logic [7:0] words [4];
   logic [17:0] exp_out;
   int hb0, hb1;

   initial begin
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

      // Scenario 1: reset, then round-robin streaming with sinks always ready
      #3;
      check_eq("rst_ctrl", {in_ready, out0_valid, out1_valid, sel, busy}, 0);
      check_eq("rst_data", {out0_data, out1_data}, 0);
      #19 rst = 1'b0;
      #1 check_eq("rdy_before_edge", in_ready, 0);
      @(posedge clk); #1;
      check_eq("rdy_after_edge", in_ready, 1);

      in_valid = 1'b1;
      in_data  = words[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i < 3) in_data = words[i+1];
         else       in_valid = 1'b0;
         @(negedge clk);
         exp_out = (i % 2 == 1) ? {1'b0, 8'h00, 1'b1, words[i]} : {1'b1, words[i], 1'b0, 8'h00};
         check_eq($sformatf("rr_out_%0d", i), {out0_valid, out0_data, out1_valid, out1_data}, exp_out);
         check_eq($sformatf("rr_sel_rdy_%0d", i), {sel, busy, in_ready}, {(i % 2 == 1), 1'b1, 1'b1});
      end
      @(posedge clk); #1;
      check_eq("rr_idle_busy", busy, 0);
      check_eq("rr_counts", {h0[7:0], h1[7:0]}, {8'd2, 8'd2});
      check_eq("rr_last", {last0, last1}, {8'h33, 8'h44});

      // Scenario 2: directed to out1 with 5 cycles of backpressure
      mode = 1'b1; in_dest = 1'b1; out1_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'hA5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      hb1 = h1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("bp_hold_%0d", i), {out1_valid, out1_data, in_ready, out0_valid, sel},
                  {1'b1, 8'hA5, 1'b0, 1'b0, 1'b1});
         @(posedge clk); #1;
      end
      out1_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_ready_follows", in_ready, 1);
      @(posedge clk); #1;
      check_eq("bp_one_xfer", h1 - hb1, 1);
      check_eq("bp_xfer_data", last1, 8'hA5);
      check_eq("bp_idle", busy, 0);

      // Scenario 3: mode flipped while holding a round-robin word for out0
      mode = 1'b0; out0_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h5A;
      @(posedge clk); #1;
      in_valid = 1'b0; mode = 1'b1; in_dest = 1'b1;
      hb0 = h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq($sformatf("mode_hold_%0d", i), {out0_valid, out0_data, out1_valid, sel},
                  {1'b1, 8'h5A, 1'b0, 1'b0});
      end
      out0_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("mode_xfer", {h0 - hb0, 24'(last0)}, {32'd1, 24'h5A});
      mode = 1'b0;
      in_valid = 1'b1; in_data = 8'h66;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("rr_toggled", {out1_valid, out1_data, out0_valid}, {1'b1, 8'h66, 1'b0});
      @(posedge clk); #1;

      // Scenario 4: reset while holding 0x77 for out1
      mode = 1'b1; in_dest = 1'b1; out1_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      hb1 = h1;
      @(negedge clk);
      check_eq("pre_rst_hold", {out1_valid, out1_data}, {1'b1, 8'h77});
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_ctrl", {in_ready, out0_valid, out1_valid, sel, busy}, 0);
      check_eq("async_rst_data", {out0_data, out1_data}, 0);
      @(posedge clk); #1;
      out1_ready = 1'b1;
      #2 rst = 1'b0;
      #1 check_eq("rst_rdy_low", in_ready, 0);
      @(posedge clk); #1;
      check_eq("rst_rdy_high", {in_ready, out1_valid}, {1'b1, 1'b0});
      repeat (2) @(posedge clk);
      #1 check_eq("rst_no_deliver", h1 - hb1, 0);
`ifdef DEMUX_SCHED_STATS_EN
      check_eq("cnt_rst", {cnt0, cnt1}, 0);
`endif

      // Scenario 5: 17 directed words to out0 back to back
      mode = 1'b1; in_dest = 1'b0; out0_ready = 1'b1;
      hb0 = h0;
      in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 8'(i + 8'h80);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("burst_xfers", h0 - hb0, 17);
      check_eq("burst_last", last0, 8'h90);
`ifdef DEMUX_SCHED_STATS_EN
      check_eq("cnt0_wrap", cnt0, 4'd1);
      check_eq("cnt1_zero", cnt1, 4'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/demux_1x2_sched.md
DEMUX_1X2_SCHED -- requirements
Module: demux_1x2_sched

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits.
REQ-002 Parameter: CNT_W, default 16, statistics counter width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  upstream payload.
- in_dest  input  1  requested output in directed mode.
- mode  input  1  0 = round-robin, 1 = directed by in_dest.
- out0_valid / out1_valid  output  1  channel word valid.
- out0_ready / out1_ready  input  1  channel sink ready.
- out0_data / out1_data  output  DATA_W  channel payload.
- sel  output  1  output currently targeted by the held word.
- busy  output  1  a word is held.
- cnt0 / cnt1  output  CNT_W  words delivered per channel (only with DEMUX_SCHED_STATS_EN).

Function
REQ-004 FSM states SHALL be IDLE, HOLD0 and HOLD1, with one holding register of DATA_W bits.
REQ-005 A word is accepted when in_valid && in_ready at a clk edge; an output transfer completes when outN_valid && outN_ready at a clk edge.
REQ-006 in_ready SHALL be 1 in IDLE, and equal to the selected channel's outN_ready in HOLDn (combinational), giving one word per cycle sustained throughput.
REQ-007 On accept, the target SHALL be in_dest when mode=1, or the round-robin pointer rr when mode=0.
- The word is registered and the FSM moves to HOLD0 or HOLD1.
- Latency: in_data SHALL appear on outN_data exactly one cycle after accept.
REQ-008 In HOLDn, outN_valid=1 and outN_data = held word; the other channel SHALL drive valid=0 and data=0.
REQ-009 The held word and the target SHALL stay stable until the transfer completes; backpressure of any length SHALL be tolerated without loss.
REQ-010 Transfer completes with no simultaneous accept: the FSM SHALL return to IDLE.
REQ-011 Transfer completes with a simultaneous accept: the FSM SHALL load the new word and go directly to HOLD0 or HOLD1 per REQ-007.
REQ-012 rr SHALL toggle on each completed transfer made in mode 0, and SHALL be unchanged by mode-1 transfers.
- When completion and accept coincide, the new target SHALL use the toggled rr value.
REQ-013 mode and in_dest SHALL be sampled only at accept; changing them while holding SHALL have no effect on the held word.
REQ-014 In IDLE: sel SHALL be 0 and busy SHALL be 0. In HOLDn: sel = n and busy = 1.

Reset
REQ-015 While rst=1, asynchronously:
- state = IDLE; rr = 0; holding register = 0.
- in_ready = 0, all valids = 0, all data = 0, sel = 0, busy = 0, counters = 0.
REQ-016 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-017 Reset during HOLDn SHALL discard the held word with no output transfer.

Configuration
REQ-018 Macro DEMUX_SCHED_STATS_EN:
- Defined: cnt0 and cnt1 SHALL increment on each completed transfer of their channel and wrap modulo 2^CNT_W.
- Undefined: the cnt0 and cnt1 ports and their logic SHALL be absent.

Structure
REQ-019 A shared package demux_sched_pkg SHALL hold the state enum type (IDLE, HOLD0, HOLD1) and the mode encodings MODE_RR=0 and MODE_DIR=1.
REQ-020 The existing combinational 1x2 demux SHALL be instantiated once as the sub-module that steers the holding register to outN_data under sel, gated by busy.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, mode=0, outputs always ready, words 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> out0 gets 0x11 and 0x33, out1 gets 0x22 and 0x44, one word per cycle, each one cycle after accept.
- mode=1, in_dest=1, 0xA5 accepted, out1_ready=0 for 5 cycles -> out1_valid=1 with 0xA5 held for 5 cycles, in_ready=0 throughout, out0_valid=0; one transfer when ready rises.
- mode switched from 0 to 1 while holding 0x5A for out0 -> 0x5A still delivered on out0, and rr toggles once.
- rst pulsed mid-HOLD1 holding 0x77 -> all outputs 0 immediately, 0x77 never delivered, in_ready=1 one edge after release.
- STATS_EN defined, CNT_W=4, 17 words to out0 in mode 1 -> cnt0 = 1 (wrapped), cnt1 = 0.
